// File: rtl/particle_streamer_pkg.sv
// Shared definitions for the particle streamer, the pusher datapath and the particle memory.
package particle_streamer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } streamer_state_t;

   localparam int unsigned DEF_PART_W        = 64;
   localparam int unsigned DEF_NUM_PARTICLES = 1024;

endpackage

// File: rtl/stream_buf.sv
// Synchronous first-word-fall-through FIFO; flush has priority over push and pop.
module stream_buf #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] incr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem[rd_ptr_q];
   assign do_push = push && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= incr(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= incr(rd_ptr_q);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

   // The upstream credit rule must keep a push off a full buffer unless a pop frees a slot.
   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(do_push && !do_pop && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/particle_streamer.sv
// Walks particle memory once per step, buffers read data under credit control and
// streams it to the pusher, signalling completion once every particle is written back.
module particle_streamer #(
   parameter int NUM_PARTICLES = particle_streamer_pkg::DEF_NUM_PARTICLES,
   parameter int ADDR_W        = 10,
   parameter int PART_W        = particle_streamer_pkg::DEF_PART_W,
   parameter int RD_LAT        = 2,
   parameter int BUF_DEPTH     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_ready,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [PART_W-1:0] mem_rd_data,
   output logic              out_valid,
   output logic [PART_W-1:0] out_data,
   input  logic              out_ready,
   input  logic              wb_valid,
   output logic              pusher_done,
   output logic [31:0]       issued_cnt
);

   import particle_streamer_pkg::*;

   localparam int                CNT_W     = $clog2(BUF_DEPTH + 1);
   localparam logic [31:0]       N_PART    = 32'(NUM_PARTICLES);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PARTICLES - 1);

   streamer_state_t   state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [31:0]       issued_q, issued_d, wb_q, wb_d;
   logic [RD_LAT-1:0] pipe_q, pipe_shift;
   logic              active, abort, issue, accept, buf_empty;
   logic [CNT_W-1:0]  buf_count;
   logic [PART_W-1:0] buf_head;

   assign active = (state_q == STREAM) || (state_q == DRAIN);
   assign abort  = active && !fifo_ready;
   // Credits: buffer slots not yet claimed by stored data or reads still in flight.
   assign issue  = (state_q == STREAM) && fifo_ready &&
                   ((int'(buf_count) + $countones(pipe_q)) < BUF_DEPTH);
   assign accept = out_valid && out_ready;

   if (RD_LAT == 1) begin : g_pipe_one
      assign pipe_shift = issue;
   end else begin : g_pipe_multi
      assign pipe_shift = {pipe_q[RD_LAT-2:0], issue};
   end

   stream_buf #(
      .DEPTH(BUF_DEPTH),
      .WIDTH(PART_W)
   ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .flush    (abort),
      .push     (pipe_q[RD_LAT-1]),
      .push_data(mem_rd_data),
      .pop      (accept),
      .head     (buf_head),
      .empty    (buf_empty),
      .count    (buf_count)
   );

   assign mem_rd_en   = issue;
   assign mem_rd_addr = issue ? rd_addr_q : '0;
   assign out_valid   = active && !buf_empty;
   assign out_data    = out_valid ? buf_head : '0;
   assign pusher_done = (state_q == DONE);
   assign issued_cnt  = issued_q;

   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      issued_d  = issued_q;
      wb_d      = wb_q;
      if (issue)  rd_addr_d = rd_addr_q + 1'b1;
      if (accept) issued_d  = issued_q + 32'd1;
      if (active && wb_valid && wb_q != N_PART) wb_d = wb_q + 32'd1;
      case (state_q)
         IDLE: begin
            if (fifo_ready) begin
               state_d   = STREAM;
               rd_addr_d = '0;
               issued_d  = '0;
               wb_d      = '0;
            end
         end
         STREAM: begin
            if (!fifo_ready)                           state_d = IDLE;
            else if (issue && rd_addr_q == LAST_ADDR)  state_d = DRAIN;
         end
         DRAIN: begin
            // Next-cycle counts so done follows the final write-back by one cycle.
            if (!fifo_ready)                                           state_d = IDLE;
            else if (issued_d == N_PART && wb_d == N_PART && pipe_q == '0) state_d = DONE;
         end
         DONE: begin
            if (!fifo_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE && state_q != IDLE) begin
         rd_addr_d = '0;
         issued_d  = '0;
         wb_d      = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rd_addr_q <= '0;
         issued_q  <= '0;
         wb_q      <= '0;
         pipe_q    <= '0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         issued_q  <= issued_d;
         wb_q      <= wb_d;
         pipe_q    <= abort ? '0 : pipe_shift;
      end
   end

endmodule

// File: tb/tb_particle_streamer.sv
// Directed bench for particle_streamer with 8 particles, read latency 2 and a 4-entry buffer.
module tb_particle_streamer;

   logic        clk = 1'b0;
   logic        rst, fifo_ready, out_ready, wb_valid;
   logic        mem_rd_en, out_valid, pusher_done;
   logic [9:0]  mem_rd_addr;
   logic [63:0] mem_rd_data, out_data;
   logic [31:0] issued_cnt;

   logic [9:0]  lat1_a, lat2_a;
   logic        acc1, acc2, wb_auto, wb_man;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   particle_streamer #(
      .NUM_PARTICLES(8),
      .ADDR_W       (10),
      .PART_W       (64),
      .RD_LAT       (2),
      .BUF_DEPTH    (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_ready (fifo_ready),
      .mem_rd_en  (mem_rd_en),
      .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .wb_valid   (wb_valid),
      .pusher_done(pusher_done),
      .issued_cnt (issued_cnt)
   );

   // Memory returns word = address two cycles after the read; pusher writes back two
   // cycles after each accept when wb_auto is set.
   always @(posedge clk) begin
      lat1_a <= mem_rd_addr;
      lat2_a <= lat1_a;
      acc1   <= out_valid && out_ready;
      acc2   <= acc1;
   end
   assign mem_rd_data = {54'd0, lat2_a};
   assign wb_valid    = (wb_auto && acc2) || wb_man;

   task automatic test_reset();
      rst = 1'b1; fifo_ready = 1'b0; out_ready = 1'b0; wb_auto = 1'b0; wb_man = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({mem_rd_en, mem_rd_addr, out_valid, out_data, pusher_done, issued_cnt} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: en=%0b addr=%0h v=%0b d=%0h done=%0b cnt=%0d want all 0",
                  mem_rd_en, mem_rd_addr, out_valid, out_data, pusher_done, issued_cnt);
      end
   endtask

   task automatic test_stream();
      logic exp_v;
      @(negedge clk);
      fifo_ready = 1'b1; out_ready = 1'b1; wb_auto = 1'b1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk); #1;
         exp_v = (k >= 3 && k <= 10);
         n_cmp++;
         if (out_valid !== exp_v) begin
            n_err++; $display("FAIL t1_valid c%0d: got %0b want %0b", k, out_valid, exp_v);
         end
         if (exp_v) begin
            n_cmp++;
            if (out_data !== 64'(k - 3)) begin
               n_err++; $display("FAIL t1_data c%0d: got %0d want %0d", k, out_data, k - 3);
            end
         end
         n_cmp++;
         if (mem_rd_en !== (k <= 7) || (k <= 7 && mem_rd_addr !== 10'(k))) begin
            n_err++;
            $display("FAIL t1_read c%0d: en=%0b addr=%0d want en=%0b addr=%0d",
                     k, mem_rd_en, mem_rd_addr, (k <= 7), k);
         end
         n_cmp++;
         if (pusher_done !== (k >= 13)) begin
            n_err++; $display("FAIL t1_done c%0d: got %0b want %0b", k, pusher_done, (k >= 13));
         end
      end
      n_cmp++;
      if (issued_cnt !== 32'd8) begin
         n_err++; $display("FAIL t1_issued: got %0d want 8", issued_cnt);
      end
      @(negedge clk); fifo_ready = 1'b0; #1;
      n_cmp++;
      if (pusher_done !== 1'b1) begin
         n_err++; $display("FAIL t1_done_hold: got %0b want 1", pusher_done);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (pusher_done !== 1'b0) begin
         n_err++; $display("FAIL t1_done_clear: got %0b want 0", pusher_done);
      end
   endtask

   task automatic test_toggle_ready();
      int          exp_d, rd_next, outst;
      logic        prev_stall;
      logic [63:0] prev_data;
      exp_d = 0; rd_next = 0; outst = 0; prev_stall = 1'b0; prev_data = '0;
      @(negedge clk);
      fifo_ready = 1'b1; out_ready = 1'b0; wb_auto = 1'b1;
      for (int k = 0; k < 80 && exp_d < 8; k++) begin
         @(negedge clk);
         out_ready = (k % 4 == 0) || (k % 4 == 3);
         #1;
         if (prev_stall) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== prev_data) begin
               n_err++;
               $display("FAIL t2_stable c%0d: v=%0b d=%0d want v=1 d=%0d",
                        k, out_valid, out_data, prev_data);
            end
         end
         if (mem_rd_en) begin
            n_cmp++;
            if (mem_rd_addr !== 10'(rd_next)) begin
               n_err++; $display("FAIL t2_rd_addr: got %0d want %0d", mem_rd_addr, rd_next);
            end
            rd_next++; outst++;
         end
         n_cmp++;
         if (outst > 4) begin
            n_err++; $display("FAIL t2_outstanding c%0d: got %0d want <=4", k, outst);
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (out_data !== 64'(exp_d)) begin
               n_err++; $display("FAIL t2_order: got %0d want %0d", out_data, exp_d);
            end
            exp_d++; outst--;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
      n_cmp++;
      if (exp_d != 8 || rd_next != 8) begin
         n_err++; $display("FAIL t2_count: accepted %0d read %0d want 8 and 8", exp_d, rd_next);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 30 && !pusher_done; k++) begin
         @(negedge clk); #1;
      end
      n_cmp++;
      if (pusher_done !== 1'b1) begin
         n_err++; $display("FAIL t2_done: got %0b want 1", pusher_done);
      end
      @(negedge clk); fifo_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_stall_credits();
      int rd_cnt, rd_next, exp_d;
      rd_cnt = 0; rd_next = 0; exp_d = 0;
      @(negedge clk);
      fifo_ready = 1'b1; out_ready = 1'b0; wb_auto = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); #1;
         if (mem_rd_en) rd_cnt++;
      end
      n_cmp++;
      if (rd_cnt != 4 || mem_rd_en !== 1'b0) begin
         n_err++; $display("FAIL t3_credits: reads %0d en=%0b want 4 and 0", rd_cnt, mem_rd_en);
      end
      for (int k = 0; k < 40 && exp_d < 8; k++) begin
         @(negedge clk);
         out_ready = 1'b1;
         #1;
         if (mem_rd_en) begin
            n_cmp++;
            if (mem_rd_addr !== 10'(rd_next + 4)) begin
               n_err++; $display("FAIL t3_rd_addr: got %0d want %0d", mem_rd_addr, rd_next + 4);
            end
            rd_next++;
         end
         if (out_valid) begin
            n_cmp++;
            if (out_data !== 64'(exp_d)) begin
               n_err++; $display("FAIL t3_order: got %0d want %0d", out_data, exp_d);
            end
            exp_d++;
         end
      end
      n_cmp++;
      if (exp_d != 8 || rd_next != 4) begin
         n_err++; $display("FAIL t3_count: accepted %0d late reads %0d want 8 and 4", exp_d, rd_next);
      end
      for (int k = 0; k < 30 && !pusher_done; k++) begin
         @(negedge clk); #1;
      end
      n_cmp++;
      if (pusher_done !== 1'b1) begin
         n_err++; $display("FAIL t3_done: got %0b want 1", pusher_done);
      end
      @(negedge clk); fifo_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_abort_restart();
      int acc;
      acc = 0;
      @(negedge clk);
      fifo_ready = 1'b1; out_ready = 1'b1; wb_auto = 1'b1;
      for (int k = 0; k < 20 && acc < 3; k++) begin
         @(negedge clk); #1;
         if (out_valid && out_ready) acc++;
      end
      @(negedge clk);
      fifo_ready = 1'b0; out_ready = 1'b0;
      #1;
      n_cmp++;
      if (issued_cnt !== 32'd3) begin
         n_err++; $display("FAIL t4_issued_at_abort: got %0d want 3", issued_cnt);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== '0 || pusher_done !== 1'b0 || mem_rd_en !== 1'b0) begin
         n_err++;
         $display("FAIL t4_idle: v=%0b d=%0h done=%0b en=%0b want all 0",
                  out_valid, out_data, pusher_done, mem_rd_en);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         n_cmp++;
         if (out_valid !== 1'b0 || pusher_done !== 1'b0) begin
            n_err++; $display("FAIL t4_quiet c%0d: v=%0b done=%0b want 0 0", k, out_valid, pusher_done);
         end
      end
      @(negedge clk);
      fifo_ready = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 11; k++) begin
         @(negedge clk); #1;
         if (k == 0) begin
            n_cmp++;
            if (mem_rd_en !== 1'b1 || mem_rd_addr !== 10'd0 || issued_cnt !== 32'd0) begin
               n_err++;
               $display("FAIL t4_restart: en=%0b addr=%0d cnt=%0d want 1 0 0",
                        mem_rd_en, mem_rd_addr, issued_cnt);
            end
         end
         if (k == 4) begin
            n_cmp++;
            if (issued_cnt !== 32'd1) begin
               n_err++; $display("FAIL t4_recount: got %0d want 1", issued_cnt);
            end
         end
         if (k >= 3) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 64'(k - 3)) begin
               n_err++;
               $display("FAIL t4_data c%0d: v=%0b d=%0d want 1 %0d", k, out_valid, out_data, k - 3);
            end
         end
      end
      for (int k = 0; k < 30 && !pusher_done; k++) begin
         @(negedge clk); #1;
      end
      n_cmp++;
      if (pusher_done !== 1'b1) begin
         n_err++; $display("FAIL t4_done: got %0b want 1", pusher_done);
      end
      @(negedge clk); fifo_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_writeback_gate();
      int acc;
      acc = 0;
      @(negedge clk);
      fifo_ready = 1'b1; out_ready = 1'b1; wb_auto = 1'b0;
      for (int k = 0; k < 30 && acc < 8; k++) begin
         @(negedge clk); #1;
         if (out_valid && out_ready) acc++;
      end
      n_cmp++;
      if (acc != 8) begin
         n_err++; $display("FAIL t5_accepts: got %0d want 8", acc);
      end
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); wb_man = 1'b1; #1;
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); wb_man = 1'b0; #1;
         n_cmp++;
         if (pusher_done !== 1'b0) begin
            n_err++; $display("FAIL t5_wait7 c%0d: got %0b want 0", k, pusher_done);
         end
      end
      @(negedge clk); wb_man = 1'b1; #1;
      n_cmp++;
      if (pusher_done !== 1'b0) begin
         n_err++; $display("FAIL t5_wb8_cycle: got %0b want 0", pusher_done);
      end
      @(negedge clk); wb_man = 1'b0; #1;
      n_cmp++;
      if (pusher_done !== 1'b1 || issued_cnt !== 32'd8) begin
         n_err++; $display("FAIL t5_done: done=%0b cnt=%0d want 1 8", pusher_done, issued_cnt);
      end
      @(negedge clk); fifo_ready = 1'b0; #1;
      n_cmp++;
      if (pusher_done !== 1'b1) begin
         n_err++; $display("FAIL t5_done_hold: got %0b want 1", pusher_done);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (pusher_done !== 1'b0) begin
         n_err++; $display("FAIL t5_done_clear: got %0b want 0", pusher_done);
      end
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      fifo_ready = 1'b1; out_ready = 1'b0; wb_auto = 1'b0;
      @(negedge clk); #1;
      @(negedge clk); #1;
      n_cmp++;
      if (mem_rd_en !== 1'b1) begin
         n_err++; $display("FAIL t6_inflight: en=%0b want 1", mem_rd_en);
      end
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; fifo_ready = 1'b0; #1;
      n_cmp++;
      if ({mem_rd_en, mem_rd_addr, out_valid, out_data, pusher_done, issued_cnt} !== '0) begin
         n_err++;
         $display("FAIL t6_reset_outputs: en=%0b addr=%0h v=%0b d=%0h done=%0b cnt=%0d want 0",
                  mem_rd_en, mem_rd_addr, out_valid, out_data, pusher_done, issued_cnt);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL t6_stale c%0d: out_valid=%0b want 0", k, out_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_toggle_ready();
      test_stall_credits();
      test_abort_restart();
      test_writeback_gate();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/particle_streamer.md
Name: particle_streamer

Overview:
- Feeds the particle pusher once per time step. It walks the particle memory from address 0 to NUM_PARTICLES-1 and absorbs the memory read latency in a small credit-controlled buffer.
- Presents particles to the pusher on a valid/ready stream and counts pusher write-backs.
- Raises pusher_done to the step controller when every particle has been issued, accepted and written back.
- Sits between the step controller (fifo_ready, pusher_done) and the pusher datapath.

Parameters:
- NUM_PARTICLES, 1024: particles per step; must be >= 1.
- ADDR_W, 10: particle memory address width; 2**ADDR_W >= NUM_PARTICLES.
- PART_W, 64: width of one packed particle record.
- RD_LAT, 2: fixed particle memory read latency in cycles, >= 1.
- BUF_DEPTH, 4: internal buffer entries; must be >= RD_LAT+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- fifo_ready  in  1  level from the controller; high means run the current step, and its falling edge ends or aborts the step.
- mem_rd_en  out  1  particle memory read strobe.
- mem_rd_addr  out  ADDR_W  read address.
- mem_rd_data  in  PART_W  read data, valid RD_LAT cycles after mem_rd_en.
- out_valid  out  1  particle available to the pusher.
- out_data  out  PART_W  particle record.
- out_ready  in  1  pusher accepts when out_valid && out_ready.
- wb_valid  in  1  one pulse per particle written back by the pusher.
- pusher_done  out  1  step complete (level).
- issued_cnt  out  32  particles handed to the pusher this step.

Behaviour:
- Reset (synchronous, rst high at posedge clk):
  - All outputs are 0.
  - State is IDLE.
  - All counters and the buffer are cleared.
  - The read-latency tracking pipe is cleared.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - All outputs stay low.
  - When fifo_ready=1, go to STREAM next cycle and clear rd_addr, issued_cnt and wb_cnt.
- STREAM, read issue:
  - Issue mem_rd_en with mem_rd_addr=rd_addr when credits > 0, where credits = BUF_DEPTH - occupancy - reads_in_flight.
  - rd_addr increments per issue.
  - After issuing address NUM_PARTICLES-1, go to DRAIN. No further reads.
- Read tracking:
  - A RD_LAT-deep shift pipe of valid bits tracks reads in flight.
  - Data is written into the buffer on the cycle the pipe output is 1.
  - The buffer never overflows, because of the credit rule. Overflow is an assertion failure.
- Output:
  - out_valid equals buffer not empty; out_data is the buffer head (first-word-fall-through).
  - out_valid and out_data stay stable while out_valid && !out_ready.
  - An accept (out_valid && out_ready) pops the buffer and increments issued_cnt.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - Zero-bubble throughput: with out_ready held high, one particle per cycle after an initial latency of RD_LAT+1 cycles from entering STREAM.
- wb_cnt:
  - Increments on each wb_valid in STREAM or DRAIN.
  - wb_valid in IDLE or DONE is ignored.
  - wb_cnt saturates at NUM_PARTICLES.
- DRAIN to DONE: when issued_cnt == NUM_PARTICLES and wb_cnt == NUM_PARTICLES, with the buffer and pipe empty.
- DONE:
  - pusher_done=1, registered, one cycle after the condition holds.
  - Held high until fifo_ready=0. On that cycle go to IDLE; pusher_done is 0 in the following cycle.
  - issued_cnt holds its value.
- Abort (fifo_ready=0 in STREAM or DRAIN):
  - Go to IDLE next cycle.
  - Flush the buffer and drop out_valid the same next cycle.
  - In-flight reads are discarded: the pipe is cleared, so late data is not written.
  - pusher_done is never asserted.
- Simultaneous events:
  - wb_valid and an accept in the same cycle are both counted.
  - fifo_ready falling in the same cycle as the done condition: abort wins.
- Counter widths: issued_cnt and wb_cnt are 32-bit; rd_addr is ADDR_W wide with no wrap within a step.

Decomposition:
- Shared defs package: a streamer_state_t enum (IDLE, STREAM, DRAIN, DONE) and the default PART_W and NUM_PARTICLES constants, so the pusher and the memory agree on them.
- One sub-module, stream_buf:
  - Synchronous first-word-fall-through FIFO with parameters DEPTH and WIDTH.
  - Ports: push, push_data, pop, head, empty, count, flush.
  - flush has priority over push and pop.

Test Plan (NUM_PARTICLES=8, RD_LAT=2, BUF_DEPTH=4):
- rst, then fifo_ready=1, out_ready=1, memory word = address, one wb_valid per accept two cycles later -> out_data 0..7 on consecutive cycles, first at cycle 3 after STREAM entry; pusher_done=1 one cycle after the 8th wb_valid; issued_cnt=8.
- out_ready toggling 1,0,0,1 repeatedly -> no loss or duplication of 0..7; out_data stable while stalled; never more than 4 outstanding (buffer plus in flight).
- out_ready=0 for 20 cycles after start -> exactly 4 reads issued and mem_rd_en low thereafter; release -> the remaining 4 are issued, in order.
- fifo_ready dropped after 3 accepts -> IDLE next cycle, out_valid=0, pusher_done stays 0; restart -> stream begins again at address 0 and issued_cnt counts from 0.
- All 8 accepted but only 7 wb_valid -> stays in DRAIN with pusher_done=0; the 8th wb_valid -> pusher_done=1 the next cycle; fifo_ready=0 -> pusher_done=0 the cycle after.
- rst asserted mid-STREAM with data in flight -> all outputs 0 the next cycle; no stale write into the buffer on later cycles.
